// File: rtl/mult_result_accum.sv
// Block accumulator behind the sequenced multiplier: sums 2**N_LOG2 products with
// saturation, then rounds, shifts and saturates the block sum to OUT_W bits.
module mult_result_accum #(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned ACC_W  = 12,
  parameter int unsigned OUT_W  = 10,
  parameter int unsigned SHIFT  = 2,
  parameter int unsigned N_LOG2 = 4,
  parameter bit          SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              in_ready,
  output logic              running,
  output logic [N_LOG2-1:0] count,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat
);

  localparam int unsigned EXT_W = ACC_W + 1;
  localparam logic [EXT_W-1:0]  RND      = EXT_W'((1 << SHIFT) >> 1);
  localparam logic [N_LOG2-1:0] CNT_LAST = {N_LOG2{1'b1}};
  localparam logic [ACC_W-1:0]  ACC_MAX  = SIGNED ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]  OUT_MAX  = SIGNED ? {1'b0, {(OUT_W-1){1'b1}}} : {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0]  OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, ROUND, OUT} state_e;

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                sat_acc_q, sat_acc_d;
  logic [N_LOG2-1:0]   count_q, count_d;
  logic                in_ready_q, in_ready_d;
  logic                running_q, running_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic                out_sat_q, out_sat_d;

  logic [EXT_W-1:0]    in_ext, acc_ext, sum_ext, rnd_ext, r_ext;
  logic [ACC_W-1:0]    acc_sum;
  logic                acc_ovf;
  logic [OUT_W-1:0]    out_res;
  logic                out_ovf;

  // Saturating add and block-end round/shift/saturate, one bit wider than acc.
  always_comb begin
    in_ext  = '0;
    acc_ext = '0;
    r_ext   = '0;
    acc_ovf = 1'b0;
    out_ovf = 1'b0;
    if (SIGNED) begin
      in_ext  = {{(EXT_W-IN_W){in_data[IN_W-1]}}, in_data};
      acc_ext = {acc_q[ACC_W-1], acc_q};
    end else begin
      in_ext  = {{(EXT_W-IN_W){1'b0}}, in_data};
      acc_ext = {1'b0, acc_q};
    end
    sum_ext = acc_ext + in_ext;
    rnd_ext = acc_ext + RND;
    if (SIGNED) begin
      acc_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
      r_ext   = $signed(rnd_ext) >>> SHIFT;
      out_ovf = !((&r_ext[ACC_W:OUT_W-1]) || !(|r_ext[ACC_W:OUT_W-1]));
    end else begin
      acc_ovf = sum_ext[ACC_W];
      r_ext   = rnd_ext >> SHIFT;
      out_ovf = |r_ext[ACC_W:OUT_W];
    end
    if (!acc_ovf)
      acc_sum = sum_ext[ACC_W-1:0];
    else if (SIGNED && sum_ext[ACC_W])
      acc_sum = ACC_MIN;
    else
      acc_sum = ACC_MAX;
    if (!out_ovf)
      out_res = r_ext[OUT_W-1:0];
    else if (SIGNED && r_ext[ACC_W])
      out_res = OUT_MIN;
    else
      out_res = OUT_MAX;
  end

  // Next state; status outputs are registered from the next state.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sat_acc_d  = sat_acc_q;
    count_d    = count_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (clear) begin
          acc_d     = '0;
          sat_acc_d = 1'b0;
          count_d   = '0;
          state_d   = IDLE;
        end else if (in_valid) begin
          acc_d     = acc_sum;
          sat_acc_d = sat_acc_q | acc_ovf;
          count_d   = count_q + N_LOG2'(1);
          state_d   = (count_q == CNT_LAST) ? ROUND : ACCUM;
        end
      end
      ROUND: begin
        out_data_d = out_res;
        out_sat_d  = sat_acc_q | out_ovf;
        state_d    = OUT;
      end
      OUT: begin
        acc_d     = '0;
        sat_acc_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE) || (state_d == ACCUM);
    running_d   = (state_d == ACCUM);
    out_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sat_acc_q   <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      running_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sat_acc_q   <= sat_acc_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      running_q   <= running_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign running   = running_q;
  assign count     = count_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mult_result_accum.sv
// Scoreboard bench: three accumulator configurations share one input stream and
// are checked against an integer reference model of the block arithmetic.
module tb_mult_result_accum;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       reset, clear, in_valid;
  logic [7:0] in_data;
  logic       ir[NDUT], rn[NDUT], ov[NDUT], os[NDUT];
  logic [1:0] cnt[NDUT];
  logic [5:0] od[NDUT];

  // Per-configuration accumulator width and signedness.
  int acc_w[NDUT] = '{12, 9, 12};
  bit sgn[NDUT]   = '{1'b1, 1'b1, 1'b0};

  typedef struct {
    logic [5:0] data;
    logic       sat;
    int         cyc;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   m_acc[NDUT];
  bit   m_sat[NDUT];
  int   m_cnt;
  bit   no_push;

  mult_result_accum #(.IN_W(8), .ACC_W(12), .OUT_W(6), .SHIFT(2), .N_LOG2(2), .SIGNED(1'b1)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[0]), .running(rn[0]), .count(cnt[0]), .out_valid(ov[0]),
    .out_data(od[0]), .out_sat(os[0]));
  mult_result_accum #(.IN_W(8), .ACC_W(9), .OUT_W(6), .SHIFT(2), .N_LOG2(2), .SIGNED(1'b1)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[1]), .running(rn[1]), .count(cnt[1]), .out_valid(ov[1]),
    .out_data(od[1]), .out_sat(os[1]));
  mult_result_accum #(.IN_W(8), .ACC_W(12), .OUT_W(6), .SHIFT(2), .N_LOG2(2), .SIGNED(1'b0)) u2 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[2]), .running(rn[2]), .count(cnt[2]), .out_valid(ov[2]),
    .out_data(od[2]), .out_sat(os[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic q_push(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int q_size(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t q_pop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Reference model: plain integer arithmetic with explicit clamping.
  task automatic model_clear();
    for (int k = 0; k < NDUT; k++) begin
      m_acc[k] = 0;
      m_sat[k] = 1'b0;
    end
    m_cnt = 0;
  endtask

  task automatic model_add(input logic [7:0] d);
    int v, lo, hi;
    for (int k = 0; k < NDUT; k++) begin
      v  = sgn[k] ? int'($signed(d)) : int'(d);
      lo = sgn[k] ? -(1 << (acc_w[k] - 1)) : 0;
      hi = sgn[k] ? (1 << (acc_w[k] - 1)) - 1 : (1 << acc_w[k]) - 1;
      m_acc[k] += v;
      if (m_acc[k] > hi) begin m_acc[k] = hi; m_sat[k] = 1'b1; end
      if (m_acc[k] < lo) begin m_acc[k] = lo; m_sat[k] = 1'b1; end
    end
  endtask

  task automatic model_finish(input int c);
    int   r, lo, hi;
    exp_t e;
    for (int k = 0; k < NDUT; k++) begin
      r     = (m_acc[k] + 2) >>> 2;
      lo    = sgn[k] ? -32 : 0;
      hi    = sgn[k] ? 31 : 63;
      e.sat = m_sat[k];
      if (r > hi) begin r = hi; e.sat = 1'b1; end
      if (r < lo) begin r = lo; e.sat = 1'b1; end
      e.data = 6'(r);
      e.cyc  = c + 2;
      if (!no_push) q_push(k, e);
    end
    model_clear();
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit clr);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    clear    = clr;
  endtask

  task automatic accept(input logic [7:0] d);
    int c;
    drive(1'b1, d, 1'b0);
    c = cyc;
    model_add(d);
    m_cnt++;
    if (m_cnt == 4) model_finish(c);
  endtask

  // Two cycles where the DUT is in ROUND then OUT; in_valid may be junk.
  task automatic guard(input bit junk);
    drive(junk, 8'($urandom), 1'b0);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("dut%0d round count", k), int'(cnt[k]), 0);
      check($sformatf("dut%0d round in_ready", k), int'(ir[k]), 0);
    end
    drive(junk, 8'($urandom), 1'b0);
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, input bit junk);
    accept(a);
    accept(b);
    accept(c);
    accept(d);
    guard(junk);
  endtask

  function automatic logic [7:0] rand_sample();
    case ($urandom_range(0, 5))
      0: return 8'd127;
      1: return 8'd128;
      2: return 8'd255;
      default: return 8'($urandom);
    endcase
  endfunction

  // Monitor: pops one expectation per out_valid pulse from each configuration.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      for (int k = 0; k < NDUT; k++) begin
        if (ov[k]) begin
          if (q_size(k) == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected out_valid: got 1 expected 0 (cycle %0d)", k, cyc);
          end else begin
            e = q_pop(k);
            check($sformatf("dut%0d out_data", k), int'(od[k]), int'(e.data));
            check($sformatf("dut%0d out_sat", k), int'(os[k]), int'(e.sat));
            check($sformatf("dut%0d out_valid cycle", k), cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    no_push  = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("dut%0d reset in_ready", k), int'(ir[k]), 1);
      check($sformatf("dut%0d reset running", k), int'(rn[k]), 0);
      check($sformatf("dut%0d reset count", k), int'(cnt[k]), 0);
      check($sformatf("dut%0d reset out_valid", k), int'(ov[k]), 0);
      check($sformatf("dut%0d reset out_data", k), int'(od[k]), 0);
      check($sformatf("dut%0d reset out_sat", k), int'(os[k]), 0);
    end
    reset = 1'b0;

    send4(8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
    send4(8'd127, 8'd127, 8'd127, 8'd127, 1'b0);
    send4(8'd127, 8'd127, 8'd127, 8'h80, 1'b0);
    send4(8'hF9, 8'hF9, 8'hF9, 8'hF9, 1'b1);
    send4(8'd250, 8'd250, 8'd250, 8'd250, 1'b1);

    // Partial block aborted by clear (with in_valid high, which clear overrides).
    accept(8'd5);
    accept(8'd5);
    for (int k = 0; k < NDUT; k++)
      check($sformatf("dut%0d running mid-block", k), int'(rn[k]), 1);
    drive(1'b1, 8'd77, 1'b1);
    model_clear();
    drive(1'b0, 8'd0, 1'b0);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("dut%0d clear count", k), int'(cnt[k]), 0);
      check($sformatf("dut%0d clear running", k), int'(rn[k]), 0);
      check($sformatf("dut%0d clear in_ready", k), int'(ir[k]), 1);
    end
    send4(8'd1, 8'd1, 8'd1, 8'd1, 1'b1);

    // Reset while the block is in ROUND: no result may appear.
    no_push = 1'b1;
    accept(8'd9);
    accept(8'd9);
    accept(8'd9);
    accept(8'd9);
    no_push = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
        check($sformatf("dut%0d post-reset out_valid", k), int'(ov[k]), 0);
        check($sformatf("dut%0d post-reset count", k), int'(cnt[k]), 0);
        check($sformatf("dut%0d post-reset in_ready", k), int'(ir[k]), 1);
      end
    end

    // Randomized blocks with idle gaps and junk strobes during ROUND/OUT.
    repeat (40) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 2)) drive(1'b0, 8'($urandom), 1'b0);
        accept(rand_sample());
      end
      guard(1'($urandom_range(0, 1)));
    end

    drive(1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (q_size(0) == 0 && q_size(1) == 0 && q_size(2) == 0) break;
      @(posedge clk);
    end
    for (int k = 0; k < NDUT; k++)
      check($sformatf("dut%0d pending results", k), q_size(k), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
